// File: rtl/env_voice_alloc.sv
// Four-voice note allocator driving envelope-generator gates, with LRU ages.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all four are held.
module env_voice_alloc #(
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        note_on,
  input  logic        note_off,
  input  logic [6:0]  note,
  output logic [3:0]  gate,
  output logic [27:0] vnote,
  output logic        busy,
  output logic        drop,
  output logic        steal
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_GAP   = 1'b1;
  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  logic [3:0] gate_q, gate_n, gate_c;
  logic [6:0] vn_q [4];
  logic [1:0] age_q [4];
  logic [1:0] age_c [4];
  logic [1:0] age_n [4];
  logic       state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [1:0] pend_q, pend_n;
  logic       drop_q, steal_q;

  logic [3:0] pend_mask, off_hit, rel, live_c;
  logic       cancel;
  logic [1:0] dec;
  logic [2:0] n_live, prev_age;
  logic       hit_any, free_any, old_found;
  logic [1:0] hit_idx, free_idx, old_idx, alloc_idx;
  logic       accept, do_retrig, do_free, do_steal, do_drop, alloc, wr_en;

  always_comb begin
    pend_mask = '0;
    if (state_q == ST_GAP) pend_mask[pend_q] = 1'b1;
    cancel = note_off && (state_q == ST_GAP) && (vn_q[pend_q] == note);
    for (int unsigned i = 0; i < 4; i++)
      off_hit[i] = note_off && gate_q[i] && (vn_q[i] == note);
    rel    = off_hit | (cancel ? pend_mask : 4'b0000);
    live_c = (gate_q | pend_mask) & ~rel;
    gate_c = gate_q & ~off_hit;

    // Close the age gaps left by released voices so live ages stay 0..n-1.
    n_live = '0;
    dec    = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      dec = '0;
      for (int unsigned k = 0; k < 4; k++)
        if (rel[k] && (age_q[k] < age_q[j])) dec = dec + 2'd1;
      age_c[j] = age_q[j] - dec;
      n_live   = n_live + {2'b00, live_c[j]};
    end

    hit_any   = 1'b0;
    hit_idx   = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    old_found = 1'b0;
    old_idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hit_any && gate_c[i] && (vn_q[i] == note)) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
      if (!free_any && !gate_c[i]) begin
        free_any = 1'b1;
        free_idx = 2'(i);
      end
      if (!old_found && live_c[i] && (age_c[i] == 2'd3)) begin
        old_found = 1'b1;
        old_idx   = 2'(i);
      end
    end

    accept    = note_on && (state_q == ST_IDLE);
    do_retrig = accept && hit_any;
    do_free   = accept && !hit_any && free_any;
`ifdef VOICE_STEAL_EN
    do_steal  = accept && !hit_any && !free_any;
`else
    do_steal  = 1'b0;
`endif
    alloc     = do_retrig || do_free || do_steal;
    do_drop   = note_on && !alloc;
    alloc_idx = hit_any ? hit_idx : (free_any ? free_idx : old_idx);
    prev_age  = do_retrig ? {1'b0, age_c[hit_idx]} : (do_free ? n_live : 3'd3);

    for (int unsigned j = 0; j < 4; j++) begin
      age_n[j] = age_c[j];
      if (alloc) begin
        if (2'(j) == alloc_idx)
          age_n[j] = '0;
        else if (live_c[j] && ({1'b0, age_c[j]} < prev_age))
          age_n[j] = age_c[j] + 2'd1;
      end
    end

    gate_n  = gate_c;
    state_n = state_q;
    cnt_n   = cnt_q;
    pend_n  = pend_q;
    wr_en   = 1'b0;
    if (state_q == ST_GAP) begin
      if (cancel) begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end else if (ena) begin
        cnt_n = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          gate_n[pend_q] = 1'b1;
          state_n        = ST_IDLE;
        end
      end
    end
    if (do_free) begin
      gate_n[alloc_idx] = 1'b1;
      wr_en             = 1'b1;
    end
    if (do_retrig || do_steal) begin
      gate_n[alloc_idx] = 1'b0;
      wr_en             = 1'b1;
      state_n           = ST_GAP;
      cnt_n             = GAP_LOAD;
      pend_n            = alloc_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      steal_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        vn_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      gate_q  <= gate_n;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      drop_q  <= do_drop;
      steal_q <= do_steal;
      age_q   <= age_n;
      if (wr_en) vn_q[alloc_idx] <= note;
    end
  end

  always_comb begin
    vnote = '0;
    for (int unsigned i = 0; i < 4; i++) vnote[7*i +: 7] = vn_q[i];
  end

  assign gate  = gate_q;
  assign busy  = (state_q == ST_GAP);
  assign drop  = drop_q;
  assign steal = steal_q;

endmodule

// File: tb/tb_env_voice_alloc.sv
// Scoreboard bench for env_voice_alloc: LRU-queue reference model, directed scenarios, random traffic.
module tb_env_voice_alloc;

  localparam int unsigned TB_GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note = '0;
  logic [3:0]  gate;
  logic [27:0] vnote;
  logic        busy, drop, steal;

  env_voice_alloc #(.GAP(TB_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .note_on(note_on), .note_off(note_off),
    .note(note), .gate(gate), .vnote(vnote), .busy(busy), .drop(drop), .steal(steal)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  gate;
    logic [27:0] vnote;
    logic        busy;
    logic        drop;
    logic        steal;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: voices, notes, and a queue of live voices ordered oldest first.
  bit         m_gate [4];
  logic [6:0] m_note [4];
  int         order[$];
  bit         m_gap;
  int         m_rem;
  int         m_pend;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = '0;
    end
    order.delete();
    m_gap  = 1'b0;
    m_rem  = 0;
    m_pend = 0;
  endfunction

  function automatic void m_forget(int v);
    for (int k = order.size() - 1; k >= 0; k--)
      if (order[k] == v) order.delete(k);
  endfunction

  function automatic void m_touch(int v);
    m_forget(v);
    order.push_back(v);
  endfunction

  function automatic void m_start_gap(int v, logic [6:0] n);
    m_note[v] = n;
    m_gate[v] = 1'b0;
    m_gap     = 1'b1;
    m_rem     = int'(TB_GAP);
    m_pend    = v;
    m_touch(v);
  endfunction

  function automatic exp_t m_step(bit on, bit off, logic [6:0] n, bit e);
    exp_t r;
    bit   was_busy;
    int   v;
    was_busy = m_gap;
    r.cyc    = 0;
    r.drop   = 1'b0;
    r.steal  = 1'b0;
    if (off) begin
      for (int i = 0; i < 4; i++)
        if (m_gate[i] && m_note[i] == n) begin
          m_gate[i] = 1'b0;
          m_forget(i);
        end
      if (m_gap && m_note[m_pend] == n) begin
        m_gap = 1'b0;
        m_rem = 0;
        m_forget(m_pend);
      end
    end
    if (m_gap && e) begin
      m_rem--;
      if (m_rem == 0) begin
        m_gap          = 1'b0;
        m_gate[m_pend] = 1'b1;
      end
    end
    if (on) begin
      if (was_busy) r.drop = 1'b1;
      else begin
        v = -1;
        for (int i = 0; i < 4; i++) if (v < 0 && m_gate[i] && m_note[i] == n) v = i;
        if (v >= 0) m_start_gap(v, n);
        else begin
          for (int i = 0; i < 4; i++) if (v < 0 && !m_gate[i]) v = i;
          if (v >= 0) begin
            m_note[v] = n;
            m_gate[v] = 1'b1;
            m_touch(v);
          end else begin
`ifdef VOICE_STEAL_EN
            m_start_gap(order[0], n);
            r.steal = 1'b1;
`else
            r.drop = 1'b1;
`endif
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      r.gate[i]         = m_gate[i];
      r.vnote[7*i +: 7] = m_note[i];
    end
    r.busy = m_gap;
    return r;
  endfunction

  task automatic step(input bit on, input bit off, input logic [6:0] n, input bit e);
    exp_t x;
    @(posedge clk);
    #1;
    note_on  = on;
    note_off = off;
    note     = n;
    ena      = e;
    x        = m_step(on, off, n, e);
    x.cyc    = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    note_on  = 1'b0;
    note_off = 1'b0;
    ena      = 1'b0;
    #1;
    chk("rst_gate", 32'(gate), 32'h0);
    chk("rst_vnote", 32'(vnote), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop_steal", {30'd0, drop, steal}, 32'h0);
    sb.delete();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          chk("sb_stale", 32'(e.cyc), 32'(cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk("gate", 32'(gate), 32'(e.gate));
          chk("vnote", 32'(vnote), 32'(e.vnote));
          chk("busy", 32'(busy), 32'(e.busy));
          chk("drop", 32'(drop), 32'(e.drop));
          chk("steal", 32'(steal), 32'(e.steal));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_err);
    $fatal(1);
  end

  initial begin : stimulus
    m_reset();
    #5;
    chk("por_gate", 32'(gate), 32'h0);
    chk("por_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill all four voices; the first lands on voice 0.
    step(1, 0, 7'd60, 0); step(1, 0, 7'd62, 0); step(1, 0, 7'd64, 0); step(1, 0, 7'd65, 0);
    idle();
    @(negedge clk);
    chk("fill_gate", 32'(gate), 32'hf);
    chk("fill_vnote", 32'(vnote), 32'({7'd65, 7'd64, 7'd62, 7'd60}));

    step(0, 1, 7'd62, 0); idle();
    @(negedge clk);
    chk("off62_gate", 32'(gate), 32'hd);
    step(1, 0, 7'd67, 0); idle();
    @(negedge clk);
    chk("on67_voice1", 32'(vnote[13:7]), 32'd67);
    chk("on67_gate", 32'(gate), 32'hf);

    step(1, 0, 7'd70, 0); idle();
    @(negedge clk);
`ifdef VOICE_STEAL_EN
    chk("steal70_pulse", 32'(steal), 32'h1);
    chk("steal70_gate", 32'(gate), 32'he);
    step(0, 0, 7'd0, 1); step(0, 0, 7'd0, 1); idle();
    @(negedge clk);
    chk("steal70_done_gate", 32'(gate), 32'hf);
    chk("steal70_done_busy", 32'(busy), 32'h0);
`else
    chk("full70_drop", 32'(drop), 32'h1);
    chk("full70_gate", 32'(gate), 32'hf);
`endif

    // Retrigger gap, note_on dropped during the gap.
    do_reset();
    step(1, 0, 7'd60, 0); step(1, 0, 7'd60, 0); idle();
    @(negedge clk);
    chk("retrig_gate", 32'(gate), 32'h0);
    chk("retrig_busy", 32'(busy), 32'h1);
    step(1, 0, 7'd61, 0); idle();
    @(negedge clk);
    chk("gap_drop", 32'(drop), 32'h1);
    step(0, 0, 7'd0, 1); step(0, 0, 7'd0, 1); idle();
    @(negedge clk);
    chk("retrig_done_gate", 32'(gate), 32'h1);

    // Same-cycle off/on of a held note: fresh allocation, no gap.
    step(1, 1, 7'd60, 0); idle();
    @(negedge clk);
    chk("offon_gate", 32'(gate), 32'h1);
    chk("offon_busy", 32'(busy), 32'h0);

    // Cancel the pending voice while ena coincides.
    step(1, 0, 7'd60, 0); step(0, 1, 7'd60, 1); idle();
    @(negedge clk);
    chk("cancel_busy", 32'(busy), 32'h0);
    chk("cancel_gate", 32'(gate), 32'h0);
    repeat (3) step(0, 0, 7'd0, 1);

    // Reset in the middle of a gap.
    step(1, 0, 7'd62, 0); step(1, 0, 7'd62, 0); idle();
    do_reset();
    repeat (2) idle();
    repeat (3) step(0, 0, 7'd0, 1);
    idle();
    @(negedge clk);
    chk("postrst_gate", 32'(gate), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                7'($urandom_range(60, 65)), $urandom_range(0, 9) < 3);
    end

    repeat (4) idle();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
